// File: rtl/pdp1_ptr.sv
// PDP-1 high-speed paper tape reader controller: decodes rpa/rpb/rrb IOTs, paces tape lines, assembles the 18-bit reader buffer.
// Optional read-in-mode word requests are compiled in with `define PTR_RIM_EN.
module pdp1_ptr #(
   parameter int LINE_CYCLES = 2500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iot,
   input  logic [5:0]  iot_dev,
   input  logic        iot_wait,
   output logic [17:0] io_data,
   output logic        io_load,
   output logic        iot_done,
   output logic        ptr_flag,
   input  logic [7:0]  tape_line,
   input  logic        tape_valid,
   output logic        tape_ready
`ifdef PTR_RIM_EN
   ,
   input  logic        rim_req,
   output logic        rim_valid
`endif
);

   localparam int PW = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
   localparam logic [PW-1:0] PACE_LOAD = PW'(LINE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, READ, FULL} state_t;

   state_t      state, state_n;
   logic [17:0] rdr_buf, rdr_buf_n;
   logic [1:0]  count, count_n;
   logic [PW-1:0] pace, pace_n;
   logic        binary, binary_n;
   logic        wait_pend, wait_pend_n;
   logic [17:0] io_data_n;
   logic        io_load_n, ptr_flag_n;
   logic        xfer, complete;
   logic        is_rpa, is_rpb, is_rrb;
`ifdef PTR_RIM_EN
   logic        rim_mode, rim_mode_n, rim_valid_n;
`endif

   assign is_rpa     = iot && (iot_dev == 6'o01);
   assign is_rpb     = iot && (iot_dev == 6'o02);
   assign is_rrb     = iot && (iot_dev == 6'o30);
   assign tape_ready = (state == READ) && (pace == '0);
   assign xfer       = tape_valid && tape_ready;
   assign iot_done   = io_load;

   // Completion outputs are registered on the transition into FULL so they are visible during the FULL cycle.
   always_comb begin
      state_n     = state;
      rdr_buf_n   = rdr_buf;
      count_n     = count;
      binary_n    = binary;
      wait_pend_n = wait_pend;
      io_data_n   = io_data;
      io_load_n   = 1'b0;
      ptr_flag_n  = ptr_flag;
      complete    = 1'b0;
      pace_n      = (pace != '0) ? pace - PW'(1) : '0;
`ifdef PTR_RIM_EN
      rim_mode_n  = rim_mode;
      rim_valid_n = 1'b0;
`endif
      if (xfer)
         pace_n = PACE_LOAD;

      // An IOT always takes priority; a line transferred in the same cycle is consumed but dropped.
      if (is_rpa || is_rpb) begin
         rdr_buf_n   = '0;
         ptr_flag_n  = 1'b0;
         count_n     = '0;
         binary_n    = is_rpb;
         wait_pend_n = iot_wait;
         state_n     = READ;
`ifdef PTR_RIM_EN
         rim_mode_n  = 1'b0;
`endif
      end else if (is_rrb) begin
         io_data_n  = rdr_buf;
         io_load_n  = 1'b1;
         ptr_flag_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
`ifdef PTR_RIM_EN
               if (rim_req) begin
                  rdr_buf_n   = '0;
                  count_n     = '0;
                  binary_n    = 1'b1;
                  wait_pend_n = 1'b0;
                  rim_mode_n  = 1'b1;
                  state_n     = READ;
               end
`endif
            end
            READ: begin
               if (xfer) begin
                  if (!binary) begin
                     rdr_buf_n = {rdr_buf[17:8], tape_line};
                     complete  = 1'b1;
                  end else if (tape_line[7]) begin
                     rdr_buf_n = {rdr_buf[11:0], tape_line[5:0]};
                     if (count == 2'd2) begin
                        count_n  = '0;
                        complete = 1'b1;
                     end else begin
                        count_n = count + 2'd1;
                     end
                  end
               end
            end
            FULL:    state_n = IDLE;
            default: state_n = IDLE;
         endcase

         if (complete) begin
            state_n = FULL;
`ifdef PTR_RIM_EN
            if (rim_mode) begin
               rim_valid_n = 1'b1;
               io_data_n   = rdr_buf_n;
               rim_mode_n  = 1'b0;
            end else
`endif
            begin
               ptr_flag_n = 1'b1;
               if (wait_pend) begin
                  io_data_n   = rdr_buf_n;
                  io_load_n   = 1'b1;
                  wait_pend_n = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rdr_buf   <= '0;
         count     <= '0;
         pace      <= '0;
         binary    <= 1'b0;
         wait_pend <= 1'b0;
         io_data   <= '0;
         io_load   <= 1'b0;
         ptr_flag  <= 1'b0;
`ifdef PTR_RIM_EN
         rim_mode  <= 1'b0;
         rim_valid <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         rdr_buf   <= rdr_buf_n;
         count     <= count_n;
         pace      <= pace_n;
         binary    <= binary_n;
         wait_pend <= wait_pend_n;
         io_data   <= io_data_n;
         io_load   <= io_load_n;
         ptr_flag  <= ptr_flag_n;
`ifdef PTR_RIM_EN
         rim_mode  <= rim_mode_n;
         rim_valid <= rim_valid_n;
`endif
      end
   end

endmodule

// File: doc/pdp1_ptr.md
# pdp1_ptr

High-speed paper tape reader controller for the PDP-1 core: the device-side responder to the processor's IOT path. It decodes reader IOTs and pulls lines from a tape-line source through a valid/ready handshake. It assembles lines into an 18-bit reader buffer and hands the buffer back to the processor as an IO load plus an IOH-release pulse. It also drives the reader status flag used by the processor's skip/status logic.

## Interface
- LINE_CYCLES, 2500: minimum clk cycles between two accepted tape lines (reader speed pacing); legal range ≥1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- iot  in  1  one-cycle pulse when the processor executes an IOT.
- iot_dev  in  6  device code, mb[12:17] of the IOT.
- iot_wait  in  1  completion requested (processor holds IOH until iot_done).
- io_data  out  18  reader buffer value, bit 0 = MSB; valid while io_load is high.
- io_load  out  1  one-cycle pulse: processor performs io <= io_data.
- iot_done  out  1  one-cycle pulse: processor clears IOH.
- ptr_flag  out  1  reader buffer full.
- tape_line  in  8  tape line; bit 7 = channel 8 (binary hole), bits 5:0 = channels 1-6.
- tape_valid  in  1  tape_line is present.
- tape_ready  out  1  controller accepts a line; transfer when tape_valid & tape_ready in the same cycle.
- rim_req  in  1  (PTR_RIM_EN only) one-cycle read-in word request.
- rim_valid  out  1  (PTR_RIM_EN only) one-cycle pulse; io_data holds a read-in word.

## Operation
- Device codes (octal): 01 rpa (alphanumeric read), 02 rpb (binary read), 30 rrb (read reader buffer). All other codes ignored.
- States: IDLE, READ, FULL. Reset -> IDLE; buf=0, ptr_flag=0, line count=0, pace counter=0, mode=alpha; every output 0.
- rpa/rpb in any state: buf<=0, ptr_flag<=0, count<=0, latch mode and iot_wait into wait_pend, -> READ. In READ, this aborts and restarts the current read.
- rrb in any state: io_data=buf, io_load=1 and iot_done=1 on the next cycle; ptr_flag<=0; state unchanged.
- READ: tape_ready = (pace counter == 0). On a transfer the pace counter loads LINE_CYCLES-1.
  - Alpha mode: buf[10:17] <= tape_line, then -> FULL.
  - Binary mode with tape_line[7]=0: the line is consumed and discarded.
  - Binary mode with tape_line[7]=1: buf <= {buf[6:17], tape_line[5:0]}, count+1. When count reaches 3 -> FULL, count<=0.
- FULL, one cycle: ptr_flag<=1. If wait_pend, pulse io_load (io_data=buf) and iot_done, then clear wait_pend. -> IDLE.
- ptr_flag stays set until the next rpa, rpb or rrb.
- Pace counter decrements to 0 in every state and saturates at 0; tape_ready=0 outside READ.
- An iot and a tape transfer in the same cycle: the iot wins. The line is still consumed but not stored.
- Tape end, i.e. tape_valid low forever: the controller stays in READ and IOH is never released. That hang is the intended behaviour.

## Timing
- rrb: iot at cycle N -> io_load/iot_done at N+1.
- rpa: the accepting transfer at cycle N -> FULL at N+1 -> io_load/iot_done/ptr_flag visible at N+1.
- rpb: minimum latency from the first accepted line to completion is 2*LINE_CYCLES+1 cycles.
- io_load and iot_done are always single-cycle and coincident. io_data is registered and stable during the pulse.
- Reset mid-read: on the next cycle the state is IDLE, all outputs are 0, and a pending wait is dropped.

## Configuration
- PTR_RIM_EN defined:
  - rim_req/rim_valid ports exist.
  - rim_req in IDLE starts a binary read with wait_pend=0.
  - In FULL after a rim read: rim_valid pulses with io_data=buf, ptr_flag is not changed, and io_load/iot_done are not pulsed.
  - rim_req outside IDLE is ignored. An iot rpa/rpb during a rim read aborts it.
- PTR_RIM_EN undefined: the ports are absent and the controller serves IOTs only.

## Test plan
- Reset, then rrb with iot_wait=1 -> next cycle io_load=1, io_data=0, iot_done=1, ptr_flag=0.
- rpa wait, line 8'o215 after pacing -> io_data=18'o000215, io_load and iot_done pulse together, ptr_flag=1; a following rrb clears ptr_flag.
- rpb wait, lines 8'o012 (skipped), 8'o201, 8'o202, 8'o203 -> io_data=18'o010203, exactly LINE_CYCLES minimum spacing between tape_ready assertions.
- rpb without wait -> no io_load/iot_done and ptr_flag=1 after the third line; a later rrb returns the word.
- rpa then rpb after one accepted binary line -> buffer restarts; a reset mid-read kills the pending iot_done.
- PTR_RIM_EN: rim_req, lines 8'o277, 8'o200, 8'o201 -> rim_valid with io_data=18'o770001, ptr_flag still 0.
